// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg
//   Shared defaults and types for the data-side SRAM responder.
//   XLEN          : data and address width of the core.
//   DSRAM_ADDR_WD : default word-index width (2^12 words = 16 KiB).
//   DSRAM_BASE    : default byte base address of the data SRAM window.
//   resp_t        : one entry of the {rvalid, err, rdata} response pipe.
package data_sram_resp_pkg;

  localparam int XLEN          = 32;
  localparam int DSRAM_ADDR_WD = 12;
  localparam logic [XLEN-1:0] DSRAM_BASE = 32'h0000_0000;

  typedef struct packed {
    logic            rvalid;
    logic            err;
    logic [XLEN-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/dsram_bank.sv
// dsram_bank
//   2^ADDR_WD x 32 word array with four independent byte-lane write enables
//   and a registered read-first port. Contents are never reset.
//   clk   : rising-edge clock
//   we    : per-byte-lane write enables (lane i <- wdata[8i+7:8i])
//   rd_en : sample mem[idx] into rdata at this edge
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : registered read data (pre-write contents on a same-cycle write)
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WD = DSRAM_ADDR_WD
) (
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic               rd_en,
  input  logic [ADDR_WD-1:0] idx,
  input  logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_WD;

  logic [XLEN-1:0] mem [DEPTH];

  // Read and write both use non-blocking updates on the same edge, so a read
  // that coincides with a write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata <= mem[idx];
    end
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp
//   Data-side SRAM responder: accepts one request per cycle from the execute
//   stage, performs byte-enabled writes and returns read data after RD_LAT
//   (1 or 2) cycles with a valid strobe.
//
//   Handshake: there is no ready. A request (cpu_data_en and/or any
//   cpu_data_wen bit) is accepted in the cycle it is presented; each accepted
//   read yields exactly one cpu_data_rvalid pulse RD_LAT cycles later, in
//   issue order. cpu_data_rdata is only meaningful while cpu_data_rvalid=1
//   and otherwise holds its last value.
//
//   Ports:
//   clk             : rising-edge clock
//   reset           : asynchronous, active-low reset (response pipe only)
//   cpu_data_en     : read request
//   cpu_data_wen    : byte write enables
//   cpu_data_addr   : byte address, [1:0] ignored
//   cpu_data_wdata  : write data
//   cpu_data_rdata  : read data
//   cpu_data_rvalid : one-cycle strobe per accepted read
//   cpu_data_err    : out-of-range flag (with rvalid for reads, one cycle
//                     after a dropped write)
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int              ADDR_WD = DSRAM_ADDR_WD,
  parameter logic [XLEN-1:0] BASE    = DSRAM_BASE,
  parameter int              RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_data_en,
  input  logic [3:0]      cpu_data_wen,
  input  logic [XLEN-1:0] cpu_data_addr,
  input  logic [XLEN-1:0] cpu_data_wdata,
  output logic [XLEN-1:0] cpu_data_rdata,
  output logic            cpu_data_rvalid,
  output logic            cpu_data_err
);

  // Byte-offset bits [1:0] never affect the word selected.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_data_addr[1:0];

  // Word offset from BASE; BASE is aligned so its low bits drop out.
  logic [XLEN-3:0]    off_w;
  logic               in_range;
  logic [ADDR_WD-1:0] idx;

  assign off_w    = cpu_data_addr[XLEN-1:2] - BASE[XLEN-1:2];
  assign in_range = (off_w[XLEN-3:ADDR_WD] == '0);
  assign idx      = off_w[ADDR_WD-1:0];

  logic [3:0]      bank_we;
  logic [XLEN-1:0] bank_rdata;

  assign bank_we = in_range ? cpu_data_wen : 4'b0000;

  dsram_bank #(
    .ADDR_WD (ADDR_WD)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .rd_en (cpu_data_en & in_range),
    .idx   (idx),
    .wdata (cpu_data_wdata),
    .rdata (bank_rdata)
  );

  // First pipe stage: flags that travel alongside the bank's registered data.
  logic v1_q;
  logic e1_q;
  logic wr_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q     <= 1'b0;
      e1_q     <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      v1_q     <= cpu_data_en;
      e1_q     <= cpu_data_en & ~in_range;
      wr_err_q <= (|cpu_data_wen) & ~in_range;
    end
  end

  // Out-of-range reads never touched the bank, so their data is forced to 0.
  logic [XLEN-1:0] s1_data;
  assign s1_data = e1_q ? '0 : bank_rdata;

  resp_t pipe_out;

  if (RD_LAT >= 2) begin : g_lat2
    resp_t s2_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s2_q <= '0;
      end else begin
        s2_q.rvalid <= v1_q;
        s2_q.err    <= e1_q;
        if (v1_q) begin
          s2_q.rdata <= s1_data;
        end
      end
    end

    assign pipe_out = s2_q;
  end else begin : g_lat1
    // The bank register has no reset and changes on every read, so a small
    // resettable copy supplies the held value between strobes.
    logic [XLEN-1:0] hold_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_q <= '0;
      end else if (v1_q) begin
        hold_q <= s1_data;
      end
    end

    assign pipe_out = {v1_q, e1_q, (v1_q ? s1_data : hold_q)};
  end

  assign cpu_data_rvalid = pipe_out.rvalid;
  assign cpu_data_err    = pipe_out.err | wr_err_q;
  assign cpu_data_rdata  = pipe_out.rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  localparam logic [31:0] OOR_ADDR = 32'h0000_4000;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        en    = 1'b0;
  logic [3:0]  wen   = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata1, rdata2;
  logic        rv1, rv2, er1, er2;

  data_sram_resp #(.ADDR_WD(12), .BASE(32'h0), .RD_LAT(1)) dut1 (
    .clk             (clk),
    .reset           (reset),
    .cpu_data_en     (en),
    .cpu_data_wen    (wen),
    .cpu_data_addr   (addr),
    .cpu_data_wdata  (wdata),
    .cpu_data_rdata  (rdata1),
    .cpu_data_rvalid (rv1),
    .cpu_data_err    (er1)
  );

  data_sram_resp #(.ADDR_WD(12), .BASE(32'h0), .RD_LAT(2)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .cpu_data_en     (en),
    .cpu_data_wen    (wen),
    .cpu_data_addr   (addr),
    .cpu_data_wdata  (wdata),
    .cpu_data_rdata  (rdata2),
    .cpu_data_rvalid (rv2),
    .cpu_data_err    (er2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [int];
  // entry = {err, data, issue_cycle}
  logic [64:0] exp_q1[$];
  logic [64:0] exp_q2[$];

  logic [31:0] cyc         = 32'h0;
  logic        pend_wr_err = 1'b0;
  logic        exp_wr_err  = 1'b0;
  logic        mon_en      = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    exp_wr_err <= pend_wr_err;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    logic        inr;
    int          wi;
    logic [31:0] rd;
    logic [31:0] cur;
    inr = ((a >> 14) == 0);
    wi  = int'(a[13:2]);
    en = e; wen = w; addr = a; wdata = d;
    pend_wr_err = (w != 4'h0) && !inr;
    if (e) begin
      rd = 32'h0;
      if (inr) rd = model.exists(wi) ? model[wi] : 32'h0;
      exp_q1.push_back({~inr, rd, cyc});
      exp_q2.push_back({~inr, rd, cyc});
    end
    if (w != 4'h0 && inr) begin
      cur = model.exists(wi) ? model[wi] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (w[b]) cur[8*b +: 8] = d[8*b +: 8];
      model[wi] = cur;
    end
    @(posedge clk);
    #1;
    en = 1'b0; wen = 4'h0; pend_wr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_one(input int which, input logic rv, input logic er,
                         input logic [31:0] rd);
    logic [64:0] e;
    int          sz;
    sz = (which == 1) ? exp_q1.size() : exp_q2.size();
    if (rv) begin
      if (sz == 0) begin
        check($sformatf("dut%0d_unexpected_strobe", which), 64'd1, 64'd0);
      end else begin
        e = (which == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
        check($sformatf("dut%0d_rdata", which), {32'h0, rd}, {32'h0, e[63:32]});
        check($sformatf("dut%0d_err", which), {63'h0, er}, {63'h0, e[64]});
        check($sformatf("dut%0d_latency", which), {32'h0, cyc - e[31:0]},
              (which == 1) ? 64'd1 : 64'd2);
      end
    end else begin
      check($sformatf("dut%0d_err_no_rvalid", which), {63'h0, er}, {63'h0, exp_wr_err});
    end
  endtask

  always @(negedge clk) begin
    if (reset && mon_en) begin
      mon_one(1, rv1, er1, rdata1);
      mon_one(2, rv2, er2, rdata2);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid1", {63'h0, rv1}, 64'd0);
    check("rst_err1",    {63'h0, er1}, 64'd0);
    check("rst_rdata1",  {32'h0, rdata1}, 64'd0);
    check("rst_rvalid2", {63'h0, rv2}, 64'd0);
    check("rst_err2",    {63'h0, er2}, 64'd0);
    check("rst_rdata2",  {32'h0, rdata2}, 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // full-word write then read
    req(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    req(1'b1, 4'h0, 32'h10, 32'h0);
    idle(4);
    check("hold_rdata1", {32'h0, rdata1}, {32'h0, 32'hDEADBEEF});
    check("hold_rdata2", {32'h0, rdata2}, {32'h0, 32'hDEADBEEF});

    // partial write: expect 0x11BB33DD
    req(1'b0, 4'hF, 32'h20, 32'h11223344);
    req(1'b0, 4'b0101, 32'h20, 32'hAABBCCDD);
    req(1'b1, 4'h0, 32'h20, 32'h0);
    idle(3);

    // same-cycle read and write: old data, then new data
    req(1'b0, 4'hF, 32'h30, 32'h0);
    req(1'b1, 4'hF, 32'h30, 32'h5A5A5A5A);
    req(1'b1, 4'h0, 32'h30, 32'h0);
    idle(3);

    // read then write same word next cycle still returns old data
    req(1'b1, 4'h0, 32'h30, 32'h0);
    req(1'b0, 4'hF, 32'h30, 32'h0BADF00D);
    req(1'b1, 4'h0, 32'h30, 32'h0);
    idle(3);

    // out-of-range read and writes; 0x4010 would alias word 0x10 if unchecked
    req(1'b1, 4'h0, OOR_ADDR, 32'h0);
    idle(3);
    req(1'b0, 4'hF, OOR_ADDR, 32'h12345678);
    idle(3);
    req(1'b0, 4'hF, OOR_ADDR + 32'h10, 32'h12345678);
    idle(3);
    req(1'b1, 4'h0, 32'h10, 32'h0);
    idle(3);

    // back-to-back reads produce back-to-back strobes
    for (int i = 0; i < 4; i++) req(1'b0, 4'hF, 32'(i * 4), $urandom);
    idle(2);
    for (int i = 0; i < 4; i++) req(1'b1, 4'h0, 32'(i * 4), 32'h0);
    idle(4);

    // reset while a read is in flight
    req(1'b0, 4'hF, 32'h40, 32'hCAFEF00D);
    idle(2);
    req(1'b1, 4'h0, 32'h40, 32'h0);
    reset = 1'b0;
    exp_q1.delete();
    exp_q2.delete();
    #1;
    check("reset_drop_rvalid1", {63'h0, rv1}, 64'd0);
    check("reset_drop_rvalid2", {63'h0, rv2}, 64'd0);
    check("reset_drop_err1",    {63'h0, er1}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    req(1'b1, 4'h0, 32'h40, 32'h0);
    idle(3);

    // random in-range traffic over a small window
    for (int i = 0; i < 16; i++) req(1'b0, 4'hF, 32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      req(1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
          32'h100 + 32'($urandom_range(0, 15) * 4),
          $urandom);
    end
    idle(5);

    check("drain_q1", 64'(exp_q1.size()), 64'd0);
    check("drain_q2", 64'(exp_q2.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
